// File: rtl/multicycle_control_if.sv
// Control bundle between the multi-cycle F1 datapath (master) and its
// sequencing controller (slave).
interface multicycle_control_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       Zero;
  logic       mem_ready;
  logic       PCWrite;
  logic       IRWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUsrcA;
  logic [1:0] ALUsrcB;
  logic [2:0] ALUMode;
  logic [2:0] ImmFormat;
  logic       illegal;
  logic [3:0] state;

  modport master (
    output opcode, funct3, funct7, Zero, mem_ready,
    input  PCWrite, IRWrite, AdrSrc, MemWrite, RegWrite, ResultSrc,
           ALUsrcA, ALUsrcB, ALUMode, ImmFormat, illegal, state
  );

  modport slave (
    input  opcode, funct3, funct7, Zero, mem_ready,
    output PCWrite, IRWrite, AdrSrc, MemWrite, RegWrite, ResultSrc,
           ALUsrcA, ALUsrcB, ALUMode, ImmFormat, illegal, state
  );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle F1 CPU sequencer: fetch/decode/execute/memory/writeback FSM.
// Define MEM_WAIT_EN to let mem_ready stall FETCH, MEMREAD and MEMWRITE.
module multicycle_control (
  input  logic                 clk,
  input  logic                 rst,
  multicycle_control_if.slave  bus
);
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADDR  = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JALR     = 4'd10,
    JAL      = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_R      = 7'h33;
  localparam logic [6:0] OP_I      = 7'h13;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_JAL    = 7'h6F;

  state_t     state_q;
  logic       illegal_q;
  logic       ready;
  logic       pc_write, ir_write, mem_write, reg_write, adr_src;
  logic [1:0] result_src, src_a, src_b;
  logic [2:0] alu_mode, imm_format;

`ifdef MEM_WAIT_EN
  logic unused_funct7;
  assign ready = bus.mem_ready;
  assign unused_funct7 = ^{bus.funct7[6], bus.funct7[4:0]};
`else
  logic unused_funct7;
  assign ready = 1'b1;
  assign unused_funct7 = ^{bus.funct7[6], bus.funct7[4:0], bus.mem_ready};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FETCH;
      illegal_q <= 1'b0;
    end else begin
      case (state_q)
        FETCH:    if (ready) state_q <= DECODE;
        DECODE: begin
          case (bus.opcode)
            OP_LOAD, OP_STORE: state_q <= MEMADDR;
            OP_R:              state_q <= EXECR;
            OP_I, OP_LUI:      state_q <= EXECI;
            OP_AUIPC:          state_q <= ALUWB;
            OP_BRANCH:         state_q <= BRANCH;
            OP_JALR:           state_q <= JALR;
            OP_JAL:            state_q <= JAL;
            default: begin
              state_q   <= FETCH;
              illegal_q <= 1'b1;
            end
          endcase
        end
        MEMADDR:  state_q <= (bus.opcode == OP_STORE) ? MEMWRITE : MEMREAD;
        MEMREAD:  if (ready) state_q <= MEMWB;
        MEMWRITE: if (ready) state_q <= FETCH;
        EXECR, EXECI, JAL: state_q <= ALUWB;
        JALR:     state_q <= JAL;
        default:  state_q <= FETCH;
      endcase
    end
  end

  // Controls must react to mem_ready/Zero in the same cycle, so they are decoded from the state register.
  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    adr_src    = 1'b0;
    result_src = 2'd0;
    src_a      = 2'd0;
    src_b      = 2'd0;
    alu_mode   = 3'd0;
    imm_format = 3'd0;
    case (state_q)
      FETCH: begin
        src_b      = 2'd2;
        result_src = 2'd2;
        pc_write   = ready;
        ir_write   = ready;
      end
      DECODE: begin
        src_a = 2'd1;
        src_b = 2'd1;
        case (bus.opcode)
          OP_JAL:   imm_format = 3'd3;
          OP_AUIPC: imm_format = 3'd2;
          default:  imm_format = 3'd1;
        endcase
      end
      MEMADDR: begin
        src_a      = 2'd2;
        src_b      = 2'd1;
        imm_format = (bus.opcode == OP_STORE) ? 3'd4 : 3'd0;
      end
      MEMREAD: adr_src = 1'b1;
      MEMWB: begin
        result_src = 2'd1;
        reg_write  = 1'b1;
      end
      MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      EXECR: begin
        src_a = 2'd2;
        case (bus.funct3)
          3'd0:    alu_mode = bus.funct7[5] ? 3'd1 : 3'd0;
          3'd6:    alu_mode = 3'd3;
          3'd7:    alu_mode = 3'd2;
          default: alu_mode = 3'd0;
        endcase
      end
      EXECI: begin
        src_a = 2'd2;
        src_b = 2'd1;
        if (bus.opcode == OP_LUI) begin
          imm_format = 3'd2;
          alu_mode   = 3'd7;
        end else begin
          case (bus.funct3)
            3'd1:    alu_mode = 3'd5;
            3'd4:    alu_mode = 3'd4;
            3'd5:    alu_mode = 3'd6;
            3'd7:    alu_mode = 3'd2;
            default: alu_mode = 3'd0;
          endcase
        end
      end
      ALUWB: reg_write = 1'b1;
      BRANCH: begin
        src_a    = 2'd2;
        alu_mode = 3'd1;
        case (bus.funct3)
          3'd0:    pc_write = bus.Zero;
          3'd1:    pc_write = ~bus.Zero;
          default: pc_write = 1'b0;
        endcase
      end
      JALR: begin
        src_a = 2'd2;
        src_b = 2'd1;
      end
      JAL: begin
        pc_write = 1'b1;
        src_a    = 2'd1;
        src_b    = 2'd2;
      end
      default: ;
    endcase
  end

  // Strobes are masked by reset directly so nothing fires while reset is held.
  assign bus.PCWrite   = pc_write  & ~rst;
  assign bus.IRWrite   = ir_write  & ~rst;
  assign bus.MemWrite  = mem_write & ~rst;
  assign bus.RegWrite  = reg_write & ~rst;
  assign bus.AdrSrc    = adr_src;
  assign bus.ResultSrc = result_src;
  assign bus.ALUsrcA   = src_a;
  assign bus.ALUsrcB   = src_b;
  assign bus.ALUMode   = alu_mode;
  assign bus.ImmFormat = imm_format;
  assign bus.illegal   = illegal_q;
  assign bus.state     = state_q;
endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-instruction state walks from a
// reference model, random instruction mix, mid-instruction resets.
module tb_multicycle_control;
  logic clk;
  logic rst;
  multicycle_control_if bus ();

  multicycle_control dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef MEM_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, irw, adr, mw, rw;
    logic [1:0] rs, sa, sb;
    logic [2:0] mode, imm;
    logic       ill;
  } exp_t;

  exp_t expQ[$];
  int   seqQ[$];
  int   checks = 0;
  int   failures = 0;
  logic illSticky = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic isKnown(input logic [6:0] op);
    return op inside {7'h03, 7'h23, 7'h33, 7'h13, 7'h37, 7'h17, 7'h63, 7'h67, 7'h6F};
  endfunction

  // State walk of one instruction with every memory access completing at once.
  function automatic void buildSeq(input logic [6:0] op);
    seqQ.delete();
    case (op)
      7'h03:          seqQ = '{0, 1, 2, 3, 4};
      7'h23:          seqQ = '{0, 1, 2, 5};
      7'h33:          seqQ = '{0, 1, 6, 8};
      7'h13, 7'h37:   seqQ = '{0, 1, 7, 8};
      7'h17:          seqQ = '{0, 1, 8};
      7'h63:          seqQ = '{0, 1, 9};
      7'h67:          seqQ = '{0, 1, 10, 11, 8};
      7'h6F:          seqQ = '{0, 1, 11, 8};
      default:        seqQ = '{0, 1};
    endcase
  endfunction

  function automatic exp_t expectOut(input int st, input logic [6:0] op, input logic [2:0] f3,
                                     input logic [6:0] f7, input logic z, input logic rdy);
    exp_t e;
    e = '0;
    e.st = 4'(st);
    case (st)
      0: begin e.sb = 2'd2; e.rs = 2'd2; e.irw = rdy; e.pcw = rdy; end
      1: begin
        e.sa = 2'd1; e.sb = 2'd1;
        e.imm = (op == 7'h6F) ? 3'd3 : (op == 7'h17) ? 3'd2 : 3'd1;
      end
      2: begin e.sa = 2'd2; e.sb = 2'd1; e.imm = (op == 7'h23) ? 3'd4 : 3'd0; end
      3: e.adr = 1'b1;
      4: begin e.rs = 2'd1; e.rw = 1'b1; end
      5: begin e.adr = 1'b1; e.mw = 1'b1; end
      6: begin
        e.sa = 2'd2;
        if (f3 == 3'd0)      e.mode = f7[5] ? 3'd1 : 3'd0;
        else if (f3 == 3'd6) e.mode = 3'd3;
        else if (f3 == 3'd7) e.mode = 3'd2;
      end
      7: begin
        e.sa = 2'd2; e.sb = 2'd1;
        if (op == 7'h37) begin
          e.imm = 3'd2; e.mode = 3'd7;
        end else begin
          case (f3)
            3'd1: e.mode = 3'd5;
            3'd4: e.mode = 3'd4;
            3'd5: e.mode = 3'd6;
            3'd7: e.mode = 3'd2;
            default: e.mode = 3'd0;
          endcase
        end
      end
      8: e.rw = 1'b1;
      9: begin
        e.sa = 2'd2; e.mode = 3'd1;
        e.pcw = (f3 == 3'd0) ? z : (f3 == 3'd1) ? ~z : 1'b0;
      end
      10: begin e.sa = 2'd2; e.sb = 2'd1; end
      11: begin e.pcw = 1'b1; e.sa = 2'd1; e.sb = 2'd2; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic checkOutput(input exp_t e);
    logic [16:0] gotCtl, expCtl;
    gotCtl = {bus.PCWrite, bus.IRWrite, bus.AdrSrc, bus.MemWrite, bus.RegWrite, bus.ResultSrc,
              bus.ALUsrcA, bus.ALUsrcB, bus.ALUMode, bus.ImmFormat};
    expCtl = {e.pcw, e.irw, e.adr, e.mw, e.rw, e.rs, e.sa, e.sb, e.mode, e.imm};
    checks++;
    if (bus.state !== e.st) begin
      failures++;
      $display("[TB] FAIL state t=%0t got=%0d expected=%0d", $time, bus.state, e.st);
    end
    checks++;
    if (gotCtl !== expCtl) begin
      failures++;
      $display("[TB] FAIL controls t=%0t state=%0d got=%05h expected=%05h", $time, e.st, gotCtl, expCtl);
    end
    checks++;
    if (bus.illegal !== e.ill) begin
      failures++;
      $display("[TB] FAIL illegal t=%0t got=%0b expected=%0b", $time, bus.illegal, e.ill);
    end
  endtask

  always @(negedge clk) begin
    if (expQ.size() > 0) checkOutput(expQ.pop_front());
  end

  task automatic applyReset(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rst = 1'b1;
      bus.mem_ready = 1'b1;
      bus.Zero = 1'b1;
      e = expectOut(0, bus.opcode, bus.funct3, bus.funct7, 1'b1, 1'b0);
      e.ill = 1'b0;
      expQ.push_back(e);
    end
    illSticky = 1'b0;
  endtask

  // lowCycles < 0: random mem_ready everywhere; otherwise FETCH ready and that many stalls in memory states.
  task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                               input int zsel, input int lowCycles, input int abortAt);
    int   idx;
    int   cyc;
    int   low;
    int   st;
    logic rdy, eff, z;
    exp_t e;
    idx = 0;
    cyc = 0;
    low = lowCycles;
    buildSeq(op);
    while (idx < seqQ.size()) begin
      if (cyc == abortAt) return;
      @(posedge clk); #1;
      rst = 1'b0;
      bus.opcode = op;
      bus.funct3 = f3;
      bus.funct7 = f7;
      st = seqQ[idx];
      if (lowCycles < 0) rdy = ($urandom_range(0, 3) != 0);
      else if ((st == 3 || st == 5) && low > 0) begin rdy = 1'b0; low--; end
      else rdy = 1'b1;
      z = (zsel < 0) ? 1'($urandom_range(0, 1)) : zsel[0];
      bus.mem_ready = rdy;
      bus.Zero = z;
      eff = WAIT_EN ? rdy : 1'b1;
      e = expectOut(st, op, f3, f7, z, eff);
      e.ill = illSticky;
      expQ.push_back(e);
      if (st == 1 && !isKnown(op)) illSticky = 1'b1;
      if (!((st == 0 || st == 3 || st == 5) && !eff)) idx++;
      cyc++;
    end
  endtask

  logic [6:0] opTable [9] = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h37, 7'h17, 7'h63, 7'h67, 7'h6F};
  logic [6:0] badTable [4] = '{7'h7F, 7'h00, 7'h0B, 7'h73};

  initial begin
    rst = 1'b1;
    bus.opcode = 7'h13;
    bus.funct3 = 3'd0;
    bus.funct7 = 7'd0;
    bus.Zero = 1'b0;
    bus.mem_ready = 1'b1;
    applyReset(3);

    applyStimulus(7'h13, 3'd0, 7'h00, 0, 0, -1);
    applyStimulus(7'h23, 3'd2, 7'h00, 0, 3, -1);
    applyStimulus(7'h63, 3'd0, 7'h00, 1, 0, -1);
    applyStimulus(7'h63, 3'd1, 7'h00, 1, 0, -1);
    applyStimulus(7'h33, 3'd0, 7'h20, 0, 0, -1);
    applyStimulus(7'h67, 3'd0, 7'h00, 0, 0, -1);
    applyStimulus(7'h7F, 3'd0, 7'h00, 0, 0, -1);
    applyStimulus(7'h03, 3'd2, 7'h00, 0, 2, -1);
    applyStimulus(7'h6F, 3'd0, 7'h00, 0, 0, 2);
    applyReset(2);

    for (int n = 0; n < 250; n++) begin
      logic [6:0] op;
      int         abortAt;
      if ($urandom_range(0, 11) == 0) op = badTable[$urandom_range(0, 3)];
      else                            op = opTable[$urandom_range(0, 8)];
      abortAt = ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, 4)) : -1;
      applyStimulus(op, 3'($urandom_range(0, 7)), 7'($urandom_range(0, 127)), -1, -1, abortAt);
      if (abortAt >= 0) applyReset(int'($urandom_range(1, 2)));
    end

    @(posedge clk);
    @(negedge clk); #1;
    checks++;
    if (expQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain leftover=%0d expected=0", expQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
